lmem_port_arbiter: RTL

//  Shares the single layer-memory port (cwr/crd/csel/caddr_wr/caddr_rd/cdata_wr/cdata_rd)

---
 rtl/lmem_port_arbiter_if.sv | 32 +++
 rtl/lmem_port_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/lmem_port_arbiter_if.sv
// Layer-memory port bundle: engine-side command/return signals plus the shared memory port.
// slave is the arbiter's view; master is the engines/memory view.
interface lmem_port_arbiter_if #(
    parameter int N = 3
);
    logic [N-1:0]      req;
    logic [N-1:0]      we;
    logic [N-1:0]      lock;
    logic [3*N-1:0]    sel;
    logic [12*N-1:0]   addr;
    logic [20*N-1:0]   wdata;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [19:0]       rdata;
    logic              cwr;
    logic              crd;
    logic [2:0]        csel;
    logic [11:0]       caddr_wr;
    logic [11:0]       caddr_rd;
    logic [19:0]       cdata_wr;
    logic [19:0]       cdata_rd;

    modport slave (
        input  req, we, lock, sel, addr, wdata, cdata_rd,
        output gnt, rvalid, rdata, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr
    );

    modport master (
        output req, we, lock, sel, addr, wdata, cdata_rd,
        input  gnt, rvalid, rdata, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr
    );
endinterface

// File: rtl/lmem_port_arbiter.sv
// Round-robin arbiter sharing one layer-memory port among N engines, with a bounded
// grant lock for read-modify-write bursts and ID-tagged read return.
module lmem_port_arbiter #(
    parameter int N        = 3,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    lmem_port_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] lock_id;
    logic [CW-1:0] lock_cnt;
    logic [IW-1:0] rr_ptr;

    logic          held;
    logic [IW-1:0] start;
    logic          gnt_any;
    logic [IW-1:0] gid;

    logic          cwr, crd;
    logic [2:0]    csel;
    logic [11:0]   caddr_wr, caddr_rd;
    logic [19:0]   cdata_wr;

    logic [RD_LAT:0]           vld_pipe;
    logic [RD_LAT:0][IW-1:0]   id_pipe;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'((v >= N) ? v - N : v);
    endfunction

    // A lock at its limit stops holding this cycle; arbitration resumes after the owner.
    assign held  = (state == LOCKED) && (lock_cnt != CW'(LOCK_MAX));
    assign start = (state == LOCKED) ? wrap(int'(lock_id) + 1) : rr_ptr;

    always_comb begin
        gnt_any = 1'b0;
        gid     = '0;
        if (held) begin
            if (bus.req[lock_id]) begin
                gnt_any = 1'b1;
                gid     = lock_id;
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                if (!gnt_any && bus.req[wrap(int'(start) + j)]) begin
                    gnt_any = 1'b1;
                    gid     = wrap(int'(start) + j);
                end
            end
        end
    end

    assign bus.gnt      = gnt_any ? (N'(1) << gid) : '0;
    assign bus.rvalid   = vld_pipe[RD_LAT] ? (N'(1) << id_pipe[RD_LAT]) : '0;
    assign bus.rdata    = bus.cdata_rd;
    assign bus.cwr      = cwr;
    assign bus.crd      = crd;
    assign bus.csel     = csel;
    assign bus.caddr_wr = caddr_wr;
    assign bus.caddr_rd = caddr_rd;
    assign bus.cdata_wr = cdata_wr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cwr      <= 1'b0;
            crd      <= 1'b0;
            csel     <= '0;
            caddr_wr <= '0;
            caddr_rd <= '0;
            cdata_wr <= '0;
            state    <= UNLOCKED;
            lock_id  <= '0;
            lock_cnt <= '0;
            rr_ptr   <= '0;
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            cwr  <= gnt_any && bus.we[gid];
            crd  <= gnt_any && !bus.we[gid];
            csel <= gnt_any ? bus.sel[int'(gid)*3 +: 3] : 3'd0;
            if (gnt_any && bus.we[gid]) begin
                caddr_wr <= bus.addr[int'(gid)*12 +: 12];
                cdata_wr <= bus.wdata[int'(gid)*20 +: 20];
            end
            if (gnt_any && !bus.we[gid])
                caddr_rd <= bus.addr[int'(gid)*12 +: 12];

            // Stage 0 lines up with the crd-high cycle; stage RD_LAT with cdata_rd.
            vld_pipe <= {vld_pipe[RD_LAT-1:0], gnt_any && !bus.we[gid]};
            id_pipe  <= {id_pipe[RD_LAT-1:0], gid};

            if (held) begin
                if (gnt_any && bus.lock[gid]) begin
                    lock_cnt <= lock_cnt + 1'b1;
                end else begin
                    state    <= UNLOCKED;
                    lock_cnt <= '0;
                    rr_ptr   <= start;
                end
            end else begin
                state    <= UNLOCKED;
                lock_cnt <= '0;
                rr_ptr   <= start;
                if (gnt_any) begin
                    if (bus.lock[gid]) begin
                        state    <= LOCKED;
                        lock_id  <= gid;
                        lock_cnt <= CW'(1);
                    end else begin
                        rr_ptr <= wrap(int'(gid) + 1);
                    end
                end
            end
        end
    end
endmodule
